// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix loader and matrix ALU.
// Holds the opcode map, element/matrix geometry and the loader state encoding.
package matrix_pkg;

  localparam int ELEM_W   = 16;
  localparam int DIM      = 4;
  localparam int NUM_ELEM = DIM * DIM;
  localparam int MATRIX_W = ELEM_W * NUM_ELEM;   // 256
  localparam int CNT_W    = $clog2(NUM_ELEM);
  localparam int OP_W     = 4;

  // Opcode map shared with the ALU
  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h1;
  localparam logic [OP_W-1:0] OP_SMUL  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h3;
  localparam logic [OP_W-1:0] OP_MUL   = 4'h4;
  localparam logic [OP_W-1:0] OP_TRANS = 4'h5;
  localparam logic [OP_W-1:0] OP_HADD  = 4'h6;
  localparam logic [OP_W-1:0] OP_HSUB  = 4'h7;
  localparam logic [OP_W-1:0] OP_MAX   = 4'h8;
  localparam logic [OP_W-1:0] OP_MIN   = 4'h9;
  localparam logic [OP_W-1:0] OP_AND   = 4'hA;
  localparam logic [OP_W-1:0] OP_OR    = 4'hB;
  localparam logic [OP_W-1:0] OP_XOR   = 4'hC;
  localparam logic [OP_W-1:0] OP_LAND  = 4'hD;
  localparam logic [OP_W-1:0] OP_LOR   = 4'hE;
  localparam logic [OP_W-1:0] OP_LXOR  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_ISSUE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: collects an opcode and a serial element stream into two
// 4x4 operand matrices, then issues the complete set to the matrix ALU.
// Optional build macro: MATRIX_LOADER_UNARY_SKIP_EN -- when defined, the
// transpose opcode skips the B load phase and B stays zero.
module matrix_loader
  import matrix_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [OP_W-1:0]     opcode_in,
  input  logic                op_valid_in,
  output logic                op_ready_out,
  input  logic [ELEM_W-1:0]   elem_in,
  input  logic                elem_valid_in,
  output logic                elem_ready_out,
  output logic [MATRIX_W-1:0] matrix_a_out,
  output logic [MATRIX_W-1:0] matrix_b_out,
  output logic [OP_W-1:0]     opcode_out,
  output logic                issue_valid_out,
  input  logic                issue_ready_in,
  output logic                busy_out
);

  ld_state_e                        state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q;
  logic [OP_W-1:0]                  opcode_q;
  logic [NUM_ELEM-1:0][ELEM_W-1:0]  mat_a_q, mat_b_q;

  logic op_acc, elem_acc, cnt_last, last_b, skip_b;

  assign op_acc   = (state_q == ST_IDLE) && op_valid_in;
  assign elem_acc = ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B)) && elem_valid_in;
  assign cnt_last = (cnt_q == CNT_W'(NUM_ELEM - 1));
  // Scalar multiply carries a single B element in slot 0
  assign last_b   = (opcode_q == OP_SMUL) || cnt_last;

`ifdef MATRIX_LOADER_UNARY_SKIP_EN
  assign skip_b = (opcode_q == OP_TRANS);
`else
  assign skip_b = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (op_valid_in)
                   state_d = (opcode_in == OP_NOP) ? ST_ISSUE : ST_LOAD_A;
      ST_LOAD_A: if (elem_valid_in && cnt_last)
                   state_d = skip_b ? ST_ISSUE : ST_LOAD_B;
      ST_LOAD_B: if (elem_valid_in && last_b)
                   state_d = ST_ISSUE;
      ST_ISSUE:  if (issue_ready_in)
                   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decode from the state register only
  always_comb begin
    op_ready_out    = 1'b0;
    elem_ready_out  = 1'b0;
    issue_valid_out = 1'b0;
    busy_out        = 1'b1;
    case (state_q)
      ST_IDLE:   begin op_ready_out = 1'b1; busy_out = 1'b0; end
      ST_LOAD_A: elem_ready_out  = 1'b1;
      ST_LOAD_B: elem_ready_out  = 1'b1;
      ST_ISSUE:  issue_valid_out = 1'b1;
      default:   busy_out = 1'b0;
    endcase
  end

  // Operand datapath: opcode latch, slot counter, one slot write per element.
  // Matrices are cleared on opcode accept so no stale slot survives a load.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q    <= '0;
      opcode_q <= '0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
    end else if (op_acc) begin
      cnt_q    <= '0;
      opcode_q <= opcode_in;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
    end else if (elem_acc) begin
      // counter wraps 15->0 at the A->B boundary
      cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_LOAD_A) mat_a_q[cnt_q] <= elem_in;
      else                      mat_b_q[cnt_q] <= elem_in;
    end
  end

  assign matrix_a_out = mat_a_q;
  assign matrix_b_out = mat_b_q;
  assign opcode_out   = opcode_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: table-driven directed test of the matrix loader,
// plus a hand-written mid-load reset sequence.
module tb_matrix_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   opcode;
  logic         op_valid;
  logic         op_ready;
  logic [15:0]  elem;
  logic         elem_valid;
  logic         elem_ready;
  logic [255:0] mat_a, mat_b;
  logic [3:0]   opcode_o;
  logic         issue_valid;
  logic         issue_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_loader dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .opcode_in       (opcode),
    .op_valid_in     (op_valid),
    .op_ready_out    (op_ready),
    .elem_in         (elem),
    .elem_valid_in   (elem_valid),
    .elem_ready_out  (elem_ready),
    .matrix_a_out    (mat_a),
    .matrix_b_out    (mat_b),
    .opcode_out      (opcode_o),
    .issue_valid_out (issue_valid),
    .issue_ready_in  (issue_ready),
    .busy_out        (busy)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a_base, a_step, b_base, b_step;
    int          na, nb;      // elements expected to be consumed for A / B
    int          lat;         // expected cycles to issue_valid, 0 = not checked
    int          hold;        // cycles issue_ready held low after valid
    bit          gap;         // elem_valid toggles every other cycle
    bit          rst_before;  // abort a partial load with reset first
  } rec_t;

  rec_t recs[7];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] elem_val(input logic [15:0] base, input logic [15:0] step, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return 16'(base + step * kk);
  endfunction

  function automatic logic [255:0] build(input logic [15:0] base, input logic [15:0] step, input int n);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 16; k++)
      if (k < n) m[k*16 +: 16] = elem_val(base, step, k);
    return m;
  endfunction

  task automatic partial_reset();
    @(negedge clk);
    opcode = 4'h3; op_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      op_valid = 1'b0; elem_valid = 1'b1; elem = 16'hDEA0 + 16'(i);
      @(posedge clk);
    end
    @(negedge clk);
    elem_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_a",     mat_a, '0);
    chk("rst_mid_b",     mat_b, '0);
    chk("rst_mid_op",    {252'd0, opcode_o}, '0);
    chk("rst_mid_busy",  {255'd0, busy}, '0);
    chk("rst_mid_erdy",  {255'd0, elem_ready}, '0);
    chk("rst_mid_oprdy", {255'd0, op_ready}, 256'd1);
  endtask

  task automatic run_rec(input int idx, input rec_t r);
    logic [255:0] ea, eb;
    int n, consumed, lat;
    bit drove, seen;
    ea = build(r.a_base, r.a_step, r.na);
    eb = build(r.b_base, r.b_step, r.nb);
    if (r.rst_before) partial_reset();

    @(negedge clk);
    chk($sformatf("r%0d_op_ready_idle", idx), {255'd0, op_ready}, 256'd1);
    opcode = r.op; op_valid = 1'b1;
    @(posedge clk);
    consumed = 0; seen = 0; lat = 0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      op_valid = 1'b0;
      opcode   = 4'h0;
      if (n == 1) begin
        chk($sformatf("r%0d_cleared_a", idx), mat_a, '0);
        chk($sformatf("r%0d_op_ready_busy", idx), {254'd0, op_ready, busy}, 256'd1);
      end
      if (issue_valid) begin seen = 1; lat = n; break; end
      drove = 0;
      elem_valid = 1'b0;
      if (consumed < r.na + r.nb && (!r.gap || n[0])) begin
        elem_valid = 1'b1;
        elem = (consumed < r.na) ? elem_val(r.a_base, r.a_step, consumed)
                                 : elem_val(r.b_base, r.b_step, consumed - r.na);
        drove = elem_ready;
      end
      @(posedge clk);
      if (drove) consumed++;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL r%0d_issue_timeout: no issue_valid within 300 cycles", idx);
      return;
    end
    if (r.lat != 0) chk($sformatf("r%0d_latency", idx), 256'(lat), 256'(r.lat));
    chk($sformatf("r%0d_consumed", idx), 256'(consumed), 256'(r.na + r.nb));
    chk($sformatf("r%0d_opcode", idx), {252'd0, opcode_o}, {252'd0, r.op});
    chk($sformatf("r%0d_mat_a", idx), mat_a, ea);
    chk($sformatf("r%0d_mat_b", idx), mat_b, eb);
    chk($sformatf("r%0d_issue_rdys", idx), {254'd0, elem_ready, op_ready}, '0);

    // Stall the ALU with a junk element offered; nothing may move
    for (int h = 0; h < r.hold; h++) begin
      elem_valid = 1'b1; elem = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r%0d_hold%0d_a", idx, h), mat_a, ea);
      chk($sformatf("r%0d_hold%0d_b", idx, h), mat_b, eb);
      chk($sformatf("r%0d_hold%0d_ctl", idx, h),
          {248'd0, opcode_o, issue_valid, op_ready, elem_ready, busy},
          {248'd0, r.op, 4'b1001});
    end
    elem_valid = 1'b0;
    issue_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    issue_ready = 1'b0;
    chk($sformatf("r%0d_post_issue", idx),
        {253'd0, issue_valid, op_ready, busy}, {253'd0, 3'b010});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     a_base    a_step  b_base    b_step  na  nb  lat hold gap rst
    recs[0] = '{4'h4, 16'd1,    16'd1,  16'd17,   16'd1,  16, 16, 33, 0,   0,  0};
    recs[1] = '{4'h2, 16'h0003, 16'd0,  16'h0005, 16'd0,  16, 1,  18, 2,   0,  0};
    recs[2] = '{4'h0, 16'd0,    16'd0,  16'd0,    16'd0,  0,  0,  1,  1,   0,  0};
    recs[3] = '{4'h1, 16'd100,  16'd3,  16'h8000, 16'd7,  16, 16, 0,  5,   1,  0};
    recs[4] = '{4'h3, 16'hA000, 16'd1,  16'hB000, 16'd1,  16, 16, 33, 0,   0,  1};
`ifdef MATRIX_LOADER_UNARY_SKIP_EN
    recs[5] = '{4'h5, 16'd50,   16'd2,  16'd7,    16'd5,  16, 0,  17, 1,   0,  0};
`else
    recs[5] = '{4'h5, 16'd50,   16'd2,  16'd7,    16'd5,  16, 16, 33, 1,   0,  0};
`endif
    recs[6] = '{4'hF, 16'hFFF0, 16'd1,  16'h1234, 16'h0101, 16, 16, 33, 0, 0,  0};

    rst_n = 1'b0; opcode = 4'h0; op_valid = 1'b0; elem = 16'h0;
    elem_valid = 1'b0; issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_mat_a", mat_a, '0);
    chk("reset_mat_b", mat_b, '0);
    chk("reset_ctl", {248'd0, opcode_o, issue_valid, op_ready, elem_ready, busy},
        {248'd0, 4'h0, 4'b0100});

    for (int i = 0; i < 7; i++) run_rec(i, recs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Operand-assembly stage that sits directly upstream of the matrix ALU. Accepts one opcode and a serial stream of 16-bit elements, packs them into two 256-bit 4x4 operand matrices (A, B), then presents opcode plus both matrices to the ALU with a valid/ready issue handshake. Operand count per opcode is decoded here, so the ALU always receives a complete, stable operand set.

## Interface
- ELEM_W, 16, element width in bits
- DIM, 4, matrix dimension (DIM*DIM elements per matrix)
- clk_in  input  1  single clock, rising edge
- rst_in  input  1  synchronous, active-low reset
- opcode_in  input  4  operation code, sampled on op handshake
- op_valid_in  input  1  opcode_in valid
- op_ready_out  output  1  loader can accept an opcode
- elem_in  input  16  operand element, row-major order
- elem_valid_in  input  1  elem_in valid
- elem_ready_out  output  1  loader can accept an element
- matrix_a_out  output  256  assembled matrix A
- matrix_b_out  output  256  assembled matrix B
- opcode_out  output  4  latched opcode
- issue_valid_out  output  1  operand set complete
- issue_ready_in  input  1  ALU accepts the operand set
- busy_out  output  1  high in any state other than IDLE

## Operation
- Packing: element k (0..15), row r=k/4, col c=k%4, occupies bits [16k+15:16k]; row r spans [64r+63:64r].
- States: IDLE, LOAD_A, LOAD_B, ISSUE.
- IDLE: op_ready_out=1, elem_ready_out=0. On op_valid_in: latch opcode, clear both matrices to 0, clear element counter. Next state: NOP (0) -> ISSUE; all other opcodes -> LOAD_A.
- LOAD_A: elem_ready_out=1. Each accepted element writes slot cnt of A; cnt increments. Acceptance at cnt=15 -> LOAD_B, cnt=0.
- LOAD_B: elem_ready_out=1. Writes slot cnt of B. Scalar multiply (2): single element into B slot 0 (slots 1..15 stay 0), then ISSUE. All other opcodes: 16 elements, acceptance at cnt=15 -> ISSUE.
- ISSUE: issue_valid_out=1; opcode_out and matrices held stable until issue_ready_in. Handshake -> IDLE. New opcode accepted no earlier than the cycle after the issue handshake.
- Gaps in elem_valid_in stall the state machine; no timeout.
- Elements presented while elem_ready_out=0 are ignored and not consumed.

## Timing
- Reset (rst_in=0 at a rising edge): state IDLE, cnt=0, matrix_a_out=0, matrix_b_out=0, opcode_out=0, issue_valid_out=0, elem_ready_out=0, busy_out=0, op_ready_out=1 once reset is released. Reset mid-load or mid-issue discards all partial data.
- All outputs registered; ready/valid outputs decode from the state register only.
- Opcode accepted at cycle T, back-to-back elements: binary ops issue_valid_out high at T+33; scalar multiply at T+18; NOP at T+1.
- A written element is visible on matrix_*_out the cycle after acceptance.

## Configuration
- MATRIX_LOADER_UNARY_SKIP_EN defined: transpose (5) skips LOAD_B; B stays 0; issue_valid_out at T+17.
- Undefined: transpose loads 16 B elements like a binary op (ALU ignores B); issue at T+33.

## Structure
- Shared package matrix_pkg: opcode constants (NOP..LXOR, 4'h0..4'hF), ELEM_W, DIM, MATRIX_W=256, loader state enum. The ALU imports the same package.
- Single module; no sub-module. Element write is one indexed 16-bit slot update per matrix, selected by cnt.

## Test plan
- Reset then opcode 4, elements 1..16 then 17..32 back-to-back -> issue_valid_out at T+33, A slot k = k+1, B slot k = k+17, opcode_out=4.
- Opcode 2, A = 16 x 16'h0003, B = 16'h0005 -> issue at T+18, B = 256'h5, elem_ready_out low in ISSUE.
- Opcode 0 -> issue_valid_out at T+1, both matrices 0, no elements consumed.
- Opcode 1, elem_valid_in toggling every other cycle, issue_ready_in held low 5 cycles after valid -> outputs stable throughout; IDLE the cycle after handshake; op_ready_out=0 until then.
- rst_in low after 7 A elements, then opcode 3 with full load -> A slots 7..15 never contain stale data; result equals a clean load.
- Opcode 5 with and without MATRIX_LOADER_UNARY_SKIP_EN -> issue at T+17 with B=0, respectively T+33 with B loaded.
